mem_port_arbiter: RTL and testbench

- Two-master arbiter for the single-port, 1-cycle-read-latency word RAM.
- Master 0 is the CPU and master 1 is the secondary master (DMA / UART loader). Either master issues one access per cycle through a valid/ready handshake.
- The arbiter drives the RAM strobes, steers returned read data to the owning master, and supports locked sequences (read-modify-write) through per-master lock.

---
 rtl/mem_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port word RAM (1-cycle read latency) between two
// masters: master 0 (CPU) and master 1 (DMA / UART loader). Each master
// issues at most one access per cycle through a valid/ready handshake.
// Grants are round-robin when both masters compete. A master can hold the
// port across several accesses (read-modify-write) by setting its lock bit.
// A lock is force-released after LOCK_MAX + 1 consecutive grants so the
// other master cannot starve.
//
// Parameters:
//   ADDR_W    address width on master and memory sides
//   LOCK_MAX  bound on consecutive locked grants before a forced release
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   mN_valid/addr/wmask/wdata  master N request (wmask == 0 means read)
//   mN_lock                    keep the grant after this access
//   mN_ready                   request accepted this cycle (combinational)
//   mN_rdata/mN_rvalid         read return, one cycle after acceptance
//   mem_addr/wdata/wmask       RAM request, muxed from the granted master
//   mem_rstrb                  RAM read strobe
//   mem_rdata                  RAM read data, valid 1 cycle after mem_rstrb
//
// Optional feature (macro MEM_ARB_STATS_EN):
//   stat_m0_grants, stat_m1_grants, stat_conflicts -- saturating 16-bit
//   counters of accepted transfers per master and of contended cycles.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int LOCK_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_valid,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [3:0]        m0_wmask,
    input  logic [31:0]       m0_wdata,
    input  logic              m0_lock,
    output logic              m0_ready,
    output logic [31:0]       m0_rdata,
    output logic              m0_rvalid,

    input  logic              m1_valid,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [3:0]        m1_wmask,
    input  logic [31:0]       m1_wdata,
    input  logic              m1_lock,
    output logic              m1_ready,
    output logic [31:0]       m1_rdata,
    output logic              m1_rvalid,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rstrb,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic [31:0]       mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_m0_grants,
    output logic [15:0]       stat_m1_grants,
    output logic [15:0]       stat_conflicts
`endif
);

    // lock_cnt counts locked grants after the one that entered the lock
    // state; it never exceeds LOCK_MAX-1, which is the release point.
    localparam int CNT_W = (LOCK_MAX < 2) ? 1 : $clog2(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    typedef enum logic [1:0] {
        ARB,
        LOCK0,
        LOCK1
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] lock_cnt, cnt_next;
    logic             last_grant;
    logic             rd_pending;
    logic             rd_owner;
    logic             grant0, grant1;
    logic             granted;
    logic [3:0]       sel_wmask;

    // Grant decision and next-state logic. Nothing is granted during
    // reset. A lock release only changes the state, so the other master
    // is first considered on the following cycle.
    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        state_next = state;
        cnt_next   = lock_cnt;
        if (!reset) begin
            case (state)
                ARB: begin
                    if (m0_valid && m1_valid) begin
                        if (last_grant) grant0 = 1'b1;
                        else            grant1 = 1'b1;
                    end else begin
                        grant0 = m0_valid;
                        grant1 = m1_valid;
                    end
                    if (grant0 && m0_lock) begin
                        state_next = LOCK0;
                        cnt_next   = '0;
                    end else if (grant1 && m1_lock) begin
                        state_next = LOCK1;
                        cnt_next   = '0;
                    end
                end
                LOCK0: begin
                    grant0 = m0_valid;
                    if (grant0) begin
                        if (!m0_lock || lock_cnt == CNT_LAST) state_next = ARB;
                        else cnt_next = lock_cnt + CNT_W'(1);
                    end
                end
                LOCK1: begin
                    grant1 = m1_valid;
                    if (grant1) begin
                        if (!m1_lock || lock_cnt == CNT_LAST) state_next = ARB;
                        else cnt_next = lock_cnt + CNT_W'(1);
                    end
                end
                default: state_next = ARB;
            endcase
        end
    end

    // Memory-side request mux; with no grant m0 drives address/data but
    // both strobes stay low.
    always_comb begin
        granted   = grant0 | grant1;
        sel_wmask = grant1 ? m1_wmask : m0_wmask;
        mem_addr  = grant1 ? m1_addr  : m0_addr;
        mem_wdata = grant1 ? m1_wdata : m0_wdata;
        mem_wmask = granted ? sel_wmask : 4'b0000;
        mem_rstrb = granted && (sel_wmask == 4'b0000);
        m0_ready  = grant0;
        m1_ready  = grant1;
    end

    // Arbitration state and read-return tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB;
            lock_cnt   <= '0;
            last_grant <= 1'b1;
            rd_pending <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            state      <= state_next;
            lock_cnt   <= cnt_next;
            rd_pending <= mem_rstrb;
            if (granted) last_grant <= grant1;
            if (mem_rstrb) rd_owner <= grant1;
        end
    end

    // rvalid is masked by reset so a read accepted just before reset
    // never returns.
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;
    assign m0_rvalid = !reset && rd_pending && !rd_owner;
    assign m1_rvalid = !reset && rd_pending &&  rd_owner;

`ifdef MEM_ARB_STATS_EN
    // Saturating event counters; a conflict is any cycle with both
    // masters requesting, since exactly one of them is then refused.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_m0_grants <= '0;
            stat_m1_grants <= '0;
            stat_conflicts <= '0;
        end else begin
            if (grant0 && stat_m0_grants != 16'hFFFF)
                stat_m0_grants <= stat_m0_grants + 16'd1;
            if (grant1 && stat_m1_grants != 16'hFFFF)
                stat_m1_grants <= stat_m1_grants + 16'd1;
            if (m0_valid && m1_valid && stat_conflicts != 16'hFFFF)
                stat_conflicts <= stat_conflicts + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Drives both masters (directed scenarios, then random traffic with random
// resets) against a small RAM model. A reference model tracks ownership of
// the port as "free" or "held by N for k grants", predicts grants and memory
// strobes each cycle, and pushes expected read data into per-master queues
// that are popped whenever the DUT raises rvalid.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 32;
    localparam int LOCK_MAX = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              m0_valid = 1'b0, m1_valid = 1'b0;
    logic [ADDR_W-1:0] m0_addr = '0, m1_addr = '0;
    logic [3:0]        m0_wmask = '0, m1_wmask = '0;
    logic [31:0]       m0_wdata = '0, m1_wdata = '0;
    logic              m0_lock = 1'b0, m1_lock = 1'b0;
    logic              m0_ready, m1_ready, m0_rvalid, m1_rvalid;
    logic [31:0]       m0_rdata, m1_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rstrb;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wmask;
    logic [31:0]       mem_rdata = '0;
`ifdef MEM_ARB_STATS_EN
    logic [15:0]       stat_m0_grants, stat_m1_grants, stat_conflicts;
`endif

    mem_port_arbiter #(.ADDR_W(ADDR_W), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wmask(m0_wmask),
        .m0_wdata(m0_wdata), .m0_lock(m0_lock), .m0_ready(m0_ready),
        .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wmask(m1_wmask),
        .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_ready(m1_ready),
        .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_m0_grants(stat_m0_grants), .stat_m1_grants(stat_m1_grants),
        .stat_conflicts(stat_conflicts)
`endif
    );

    always #5 clk = ~clk;

    // RAM seen by the DUT: 16 words, 1-cycle read latency.
    logic [31:0] ram [16];
    always @(posedge clk) begin
        if (mem_rstrb) mem_rdata <= ram[mem_addr[5:2]];
        for (int b = 0; b < 4; b++)
            if (mem_wmask[b]) ram[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model state.
    logic [31:0] shadow [16];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    int          owner = -1;
    int          seq = 0;
    int          last = 1;
    logic [1:0]  exp_rv = 2'b00;
    logic        acc0 = 1'b0, acc1 = 1'b0;
    int          s0 = 0, s1 = 0, sc = 0;

    // Monitor / scoreboard: runs mid-cycle, compares, then advances model.
    always @(negedge clk) begin
        logic        e0, e1, g, lk, rd;
        logic [3:0]  wm;
        logic [31:0] a, d, got;
        e0 = 1'b0;
        e1 = 1'b0;
        if (reset) begin
            checkOutput("reset_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
            checkOutput("reset_strobes", {27'd0, mem_rstrb, mem_wmask}, 32'd0);
            checkOutput("reset_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
            owner = -1; seq = 0; last = 1; exp_rv = 2'b00;
            q0.delete(); q1.delete();
            acc0 = 1'b0; acc1 = 1'b0;
            s0 = 0; s1 = 0; sc = 0;
        end else begin
            if (owner == 0)      e0 = m0_valid;
            else if (owner == 1) e1 = m1_valid;
            else if (m0_valid && m1_valid) begin
                if (last == 1) e0 = 1'b1; else e1 = 1'b1;
            end else begin
                e0 = m0_valid; e1 = m1_valid;
            end
            g  = e1;
            wm = g ? m1_wmask : m0_wmask;
            a  = g ? m1_addr  : m0_addr;
            d  = g ? m1_wdata : m0_wdata;
            lk = g ? m1_lock  : m0_lock;
            rd = (e0 || e1) && (wm == 4'b0000);
            checkOutput("ready", {30'd0, m1_ready, m0_ready}, {30'd0, e1, e0});
            checkOutput("mem_addr", mem_addr, a);
            checkOutput("mem_wdata", mem_wdata, d);
            checkOutput("mem_wmask", {28'd0, mem_wmask}, (e0 || e1) ? {28'd0, wm} : 32'd0);
            checkOutput("mem_rstrb", {31'd0, mem_rstrb}, {31'd0, rd});
            checkOutput("rvalid", {30'd0, m1_rvalid, m0_rvalid}, {30'd0, exp_rv});
            if (m0_rvalid && exp_rv[0] && q0.size() > 0) begin
                got = q0.pop_front();
                checkOutput("m0_rdata", m0_rdata, got);
            end
            if (m1_rvalid && exp_rv[1] && q1.size() > 0) begin
                got = q1.pop_front();
                checkOutput("m1_rdata", m1_rdata, got);
            end
            exp_rv = 2'b00;
            if (m0_valid && m1_valid) sc = (sc < 65535) ? sc + 1 : sc;
            if (e0 || e1) begin
                if (g) s1 = (s1 < 65535) ? s1 + 1 : s1;
                else   s0 = (s0 < 65535) ? s0 + 1 : s0;
                if (rd) begin
                    exp_rv = g ? 2'b10 : 2'b01;
                    if (g) q1.push_back(shadow[a[5:2]]);
                    else   q0.push_back(shadow[a[5:2]]);
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (wm[b]) shadow[a[5:2]][8*b +: 8] = d[8*b +: 8];
                end
                if (owner < 0) begin
                    if (lk) begin owner = g ? 1 : 0; seq = 1; end
                end else begin
                    seq++;
                    if (!lk || seq == LOCK_MAX + 1) owner = -1;
                end
                last = g ? 1 : 0;
            end
            acc0 = e0;
            acc1 = e1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int m, input logic v, input logic [31:0] a,
                                 input logic [3:0] w, input logic [31:0] d,
                                 input logic l);
        if (m == 0) begin
            m0_valid = v; m0_addr = a; m0_wmask = w; m0_wdata = d; m0_lock = l;
        end else begin
            m1_valid = v; m1_addr = a; m1_wmask = w; m1_wdata = d; m1_lock = l;
        end
    endtask

    task automatic idleBoth();
        applyStimulus(0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        applyStimulus(1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    endtask

    task automatic randomRequest(input int m);
        logic [3:0] w;
        w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        applyStimulus(m, $urandom_range(0, 3) != 0, {26'd0, 4'($urandom_range(0, 15)), 2'b00},
                      w, $urandom, $urandom_range(0, 2) == 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ram[i] = $urandom;
            shadow[i] = ram[i];
        end
        ram[4] = 32'hDEADBEEF;
        shadow[4] = 32'hDEADBEEF;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;

        // m0 read of 0x10 with m1 idle
        applyStimulus(0, 1'b1, 32'h10, 4'h0, 32'h0, 1'b0);
        tick();
        idleBoth();
        tick(); tick();

        // both masters hold reads for 4 cycles straight out of reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(0, 1'b1, 32'h10, 4'h0, 32'h0, 1'b0);
        applyStimulus(1, 1'b1, 32'h14, 4'h0, 32'h0, 1'b0);
        repeat (4) tick();
        idleBoth();
        tick(); tick();

        // m1 byte write, then m0 reads it back
        applyStimulus(1, 1'b1, 32'h8, 4'b0100, 32'h00AB0000, 1'b0);
        tick();
        idleBoth();
        applyStimulus(0, 1'b1, 32'h8, 4'h0, 32'h0, 1'b0);
        tick();
        idleBoth();
        tick();

        // m1 locked read-modify-write of 0x20 while m0 keeps requesting
        applyStimulus(0, 1'b1, 32'h4, 4'h0, 32'h0, 1'b0);
        applyStimulus(1, 1'b1, 32'h20, 4'h0, 32'h0, 1'b1);
        tick();
        applyStimulus(1, 1'b1, 32'h20, 4'hF, 32'h12345678, 1'b0);
        tick();
        applyStimulus(1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        tick();
        idleBoth();
        tick();

        // m1 holds lock continuously; forced release lets m0 in
        applyStimulus(0, 1'b1, 32'h4, 4'h0, 32'h0, 1'b0);
        applyStimulus(1, 1'b1, 32'h24, 4'h0, 32'h0, 1'b1);
        repeat (7) tick();
        idleBoth();
        tick(); tick();

        // reset asserted right after an m0 read is accepted
        applyStimulus(0, 1'b1, 32'h10, 4'h0, 32'h0, 1'b0);
        tick();
        reset = 1'b1;
        applyStimulus(1, 1'b1, 32'h18, 4'h3, 32'hCAFEF00D, 1'b1);
        tick(); tick();
        reset = 1'b0;
        idleBoth();
        tick(); tick();

        // random traffic; requests are held until accepted
        for (int c = 0; c < 3000; c++) begin
            if (!m0_valid || acc0) randomRequest(0);
            if (!m1_valid || acc1) randomRequest(1);
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0;
        idleBoth();
        repeat (3) tick();

        checkOutput("drain_q0", q0.size(), 32'd0);
        checkOutput("drain_q1", q1.size(), 32'd0);
`ifdef MEM_ARB_STATS_EN
        checkOutput("stat_m0_grants", {16'd0, stat_m0_grants}, s0);
        checkOutput("stat_m1_grants", {16'd0, stat_m1_grants}, s1);
        checkOutput("stat_conflicts", {16'd0, stat_conflicts}, sc);
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
